// File: rtl/life_pkg.sv
// Shared definitions for the Game of Life engine: FSM states and rule thresholds.
package life_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } life_state_t;

    // A dead cell is born with exactly BIRTH neighbours; a live cell survives
    // with SURVIVE_LO..SURVIVE_HI neighbours. Four bits hold a count of 8.
    localparam logic [3:0] BIRTH      = 4'd3;
    localparam logic [3:0] SURVIVE_LO = 4'd2;
    localparam logic [3:0] SURVIVE_HI = 4'd3;

endpackage

// File: rtl/life_row.sv
// Combinational next-generation row from the three old-generation rows around it.
module life_row
    import life_pkg::*;
#(
    parameter int COLS = 8,
    parameter int WRAP = 1
) (
    input  logic [COLS-1:0] above,
    input  logic [COLS-1:0] centre,
    input  logic [COLS-1:0] below,
    output logic [COLS-1:0] next_row
);

    // Each row is extended by one cell on both sides; extended index c+1 is column c.
    // The outer cells come from the opposite edge on a torus, otherwise they are dead.
    logic [COLS+1:0] ext_a;
    logic [COLS+1:0] ext_c;
    logic [COLS+1:0] ext_b;
    logic [3:0]      n;

    assign ext_a = {(WRAP != 0) ? above[0]  : 1'b0, above,  (WRAP != 0) ? above[COLS-1]  : 1'b0};
    assign ext_c = {(WRAP != 0) ? centre[0] : 1'b0, centre, (WRAP != 0) ? centre[COLS-1] : 1'b0};
    assign ext_b = {(WRAP != 0) ? below[0]  : 1'b0, below,  (WRAP != 0) ? below[COLS-1]  : 1'b0};

    // Count the eight neighbours of every column and apply the birth/survive rule.
    always_comb begin
        next_row = '0;
        n        = '0;
        for (int c = 0; c < COLS; c++) begin
            n = {3'b000, ext_a[c]} + {3'b000, ext_a[c+1]} + {3'b000, ext_a[c+2]}
              + {3'b000, ext_c[c]}                         + {3'b000, ext_c[c+2]}
              + {3'b000, ext_b[c]} + {3'b000, ext_b[c+1]} + {3'b000, ext_b[c+2]};
            next_row[c] = (n == BIRTH) ||
                          (centre[c] && (n >= SURVIVE_LO) && (n <= SURVIVE_HI));
        end
    end

endmodule

// File: rtl/life_engine.sv
// Game of Life engine: row-serial in-place generation update over a ROWS x COLS grid.
// Load handshake: a row is written on any rising edge where load_valid and
// load_ready are both high; load_ready is high only in IDLE, and a load in that
// cycle takes priority over step/run (the step is dropped, not queued).
module life_engine
    import life_pkg::*;
#(
    parameter  int COLS  = 8,
    parameter  int ROWS  = 8,
    parameter  int WRAP  = 1,
    parameter  int GEN_W = 16,
    localparam int RW    = $clog2(ROWS)
) (
    input  logic             ph1,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [RW-1:0]    load_row,
    input  logic [COLS-1:0]  load_data,
    input  logic             step,
    input  logic             run,
    output logic             busy,
    output logic             gen_done,
    output logic [GEN_W-1:0] gen_count,
    output logic             stable,
    output logic             all_dead,
    input  logic [RW-1:0]    rd_addr,
    output logic [COLS-1:0]  rd_data,
    output life_state_t      fsm_state
);

    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [RW:0]   ROWS_W   = (RW + 1)'(ROWS);

    life_state_t     state;
    logic [COLS-1:0] grid [ROWS];
    // cnt 0 is a priming cycle that snapshots the wrap rows; cnt k updates row k-1.
    logic [RW:0]     cnt;
    logic [RW-1:0]   row_cur;
    logic [RW-1:0]   row_plus;
    logic [COLS-1:0] prev_row;    // old-generation copy of the row above row_cur
    logic [COLS-1:0] row0_copy;   // old-generation copy of row 0, used below the last row
    logic [COLS-1:0] centre_row;
    logic [COLS-1:0] below_row;
    logic [COLS-1:0] next_row;
    logic            row_diff;
    logic            changed;
    logic            load_fire;
    logic            load_in_range;

    assign row_cur       = RW'(cnt - (RW + 1)'(1));
    assign row_plus      = (row_cur == LAST_ROW) ? '0 : row_cur + RW'(1);
    assign centre_row    = grid[row_cur];
    assign row_diff      = (next_row != centre_row);
    assign load_ready    = (state == IDLE);
    assign load_fire     = load_valid && load_ready;
    assign load_in_range = ({1'b0, load_row} < ROWS_W);
    assign busy          = (state != IDLE);
    assign gen_done      = (state == DONE);
    assign fsm_state     = state;

    // Row below the one being updated: rows below are still old, except the last row.
    always_comb begin
        below_row = grid[row_plus];
        if (row_cur == LAST_ROW) begin
            below_row = (WRAP != 0) ? row0_copy : '0;
        end
    end

    life_row #(
        .COLS (COLS),
        .WRAP (WRAP)
    ) u_row (
        .above    (prev_row),
        .centre   (centre_row),
        .below    (below_row),
        .next_row (next_row)
    );

    // FSM, grid storage, row copies, generation counter and stability flag.
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            prev_row  <= '0;
            row0_copy <= '0;
            changed   <= 1'b0;
            stable    <= 1'b0;
            gen_count <= '0;
            for (int r = 0; r < ROWS; r++) begin
                grid[r] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (load_fire) begin
                        if (load_in_range) begin
                            grid[load_row] <= load_data;
                        end
                        gen_count <= '0;
                        stable    <= 1'b0;
                    end else if (step || run) begin
                        state <= COMPUTE;
                        cnt   <= '0;
                    end
                end
                COMPUTE: begin
                    cnt <= cnt + (RW + 1)'(1);
                    if (cnt == '0) begin
                        prev_row  <= (WRAP != 0) ? grid[LAST_ROW] : '0;
                        row0_copy <= grid[0];
                        changed   <= 1'b0;
                    end else begin
                        grid[row_cur] <= next_row;
                        prev_row      <= centre_row;
                        changed       <= changed || row_diff;
                        if (row_cur == LAST_ROW) begin
                            state     <= DONE;
                            stable    <= !(changed || row_diff);
                            gen_count <= gen_count + GEN_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (run && !stable) begin
                        state <= COMPUTE;
                        cnt   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Display read port; out-of-range rows read as empty.
    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_addr} < ROWS_W) begin
            rd_data = grid[rd_addr];
        end
    end

    // Grid is empty when no bit in any row is set.
    always_comb begin
        all_dead = 1'b1;
        for (int r = 0; r < ROWS; r++) begin
            if (grid[r] != '0) begin
                all_dead = 1'b0;
            end
        end
    end

endmodule

// File: doc/life_engine.md
LIFE_ENGINE -- requirements
Module: life_engine

Interface
REQ-001 SHALL have parameter COLS, default 8: cells per row; legal COLS>=3.
REQ-002 SHALL have parameter ROWS, default 8: rows in grid; legal ROWS>=3; RW=$clog2(ROWS).
REQ-003 SHALL have parameter WRAP, default 1: 1 = toroidal edges, 0 = cells outside the grid are dead.
REQ-004 SHALL have parameter GEN_W, default 16: generation counter width.
REQ-005 ph1  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 load_valid  input  1  host offers one row for writing.
REQ-008 load_ready  output  1  engine accepts a row this cycle.
REQ-009 load_row  input  RW  row index of offered data.
REQ-010 load_data  input  COLS  row contents; bit c = column c, 1 = alive.
REQ-011 step  input  1  request one generation.
REQ-012 run  input  1  compute generations back-to-back while high.
REQ-013 busy  output  1  generation in progress.
REQ-014 gen_done  output  1  one-cycle pulse per completed generation.
REQ-015 gen_count  output  GEN_W  generations completed since reset or last load.
REQ-016 stable  output  1  last generation changed no cell.
REQ-017 all_dead  output  1  every cell is 0.
REQ-018 rd_addr  input  RW  display read row index.
REQ-019 rd_data  output  COLS  row at rd_addr, combinational.

Function
REQ-020 SHALL hold the grid as ROWS registers of COLS bits.
REQ-021 SHALL apply the standard rule: a cell is alive next if it has 3 live neighbours, or it is alive with 2 live neighbours; otherwise it is dead.
REQ-022 Neighbour count SHALL be at least 4 bits wide, so a count of 8 cannot alias to 0.
REQ-023 SHALL use FSM states IDLE, COMPUTE, DONE.
REQ-024 IDLE->COMPUTE when (step|run) is high and no load is accepted that cycle.
REQ-025 COMPUTE SHALL update one row per cycle, r=0..ROWS-1, in place; COMPUTE->DONE after row ROWS-1.
REQ-026 Row r SHALL be computed from old-generation data only:
- previous row = registered copy of old row r-1;
- row 0 previous = old row ROWS-1 if WRAP, else 0;
- next row = grid[r+1];
- row ROWS-1 next = registered copy of old row 0 if WRAP, else 0;
- column wrap follows WRAP identically.
REQ-027 DONE lasts one cycle: gen_done=1; gen_count increments, wrapping from 2^GEN_W-1 to 0; stable = no cell changed during the pass.
REQ-028 DONE->COMPUTE if run=1 and stable=0; otherwise DONE->IDLE. Run therefore halts on a stable grid.
REQ-029 Latency: step sampled in IDLE at edge k -> gen_done high in the cycle after edge k+ROWS+1.
REQ-030 busy SHALL be 1 in COMPUTE and DONE, 0 in IDLE.
REQ-031 load_ready SHALL equal (state==IDLE).
REQ-032 When load_valid and load_ready are both high, grid[load_row] <= load_data; gen_count <= 0; stable <= 0.
REQ-033 Load has priority over step/run in the same cycle; the step is dropped.
REQ-034 load_row >= ROWS SHALL be accepted and discarded.
REQ-035 step or load_valid during COMPUTE/DONE SHALL be ignored; a step is not queued.
REQ-036 all_dead SHALL be the combinational NOR of all grid bits.
REQ-037 rd_data SHALL be 0 for rd_addr >= ROWS; during COMPUTE it reflects the partially updated grid.

Reset
REQ-038 Asserting reset at any time, including mid-COMPUTE, SHALL force state IDLE, grid all 0, gen_count 0, stable 0, gen_done 0, and row copies 0; after reset busy=0, load_ready=1, all_dead=1.

Structure
REQ-039 Package life_pkg SHALL hold the state enum life_state_t and the rule thresholds (BIRTH=3, SURVIVE_LO=2, SURVIVE_HI=3).
REQ-040 Sub-module life_row (combinational) SHALL compute one next-generation row from above/centre/below rows, parametrised by COLS and WRAP; it is instantiated once.

Verification (8x8 unless noted)
REQ-041 Blinker: load row3=0x1C, step -> gen_done exactly 10 cycles after the step edge; rows 2,3,4 = 0x08 each; gen_count=1; stable=0.
REQ-042 Block, run=1: rows 3,4 = 0x18 -> one generation, stable=1, FSM returns to IDLE, gen_count=1.
REQ-043 Corners, rows 0 and 7 = 0x81: WRAP=1 -> unchanged, stable=1; WRAP=0 -> all cells 0, all_dead=1.
REQ-044 Glider, WRAP=1, run=1 for 32 generations -> grid equals the initial grid; gen_count=32.
REQ-045 Load and step in the same IDLE cycle -> row written, no generation, busy stays 0; reset asserted at row 4 of COMPUTE -> grid 0, gen_count 0, load_ready=1.
